// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serializer state encodings and counter sizing
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_serializer_if.sv
// rtl/piso_tx_serializer_if.sv - load handshake and serial output bundle
interface piso_tx_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_d;
  logic             ser_en;
  logic             ser_last;
  logic             done;

  modport master (
    output load_valid, load_data,
    input  load_ready, ser_d, ser_en, ser_last, done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, ser_d, ser_en, ser_last, done
  );

endinterface

// File: rtl/shift_reg_piso.sv
// rtl/shift_reg_piso.sv - parallel-load, shift-left register with serial MSB out
module shift_reg_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // load wins over shift so a gapless reload on the final bit takes effect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/piso_tx_serializer.sv
// rtl/piso_tx_serializer.sv - MSB-first word serializer with optional even parity
module piso_tx_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  piso_tx_serializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             ser_en_q, ser_last_q, done_q;
  logic             ser_last_d;
  logic             final_bit;
  logic             accept;
  logic             sr_load, sr_shift, sr_msb;
  logic [WIDTH-1:0] sr_din;

  // The shifter drains to zero by the end of every frame, so its MSB doubles
  // as ser_d in all states; the parity bit is loaded into it for PAR.
  shift_reg_piso #(.WIDTH(WIDTH)) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (sr_msb)
  );

  assign final_bit      = (state_q == PAR) ||
                          ((state_q == SHIFT) && (cnt_q == '0) && !PARITY_EN);
  assign bus.load_ready = (state_q == IDLE) || final_bit;
  assign accept         = bus.load_valid && bus.load_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = bus.load_data;
    case (state_q)
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - 1'b1;
          sr_shift = 1'b1;
        end else if (PARITY_EN) begin
          state_d = PAR;
          sr_load = 1'b1;
          sr_din  = {par_q, {(WIDTH-1){1'b0}}};
        end else begin
          state_d  = IDLE;
          sr_shift = 1'b1;
        end
      end
      PAR: begin
        state_d  = IDLE;
        sr_shift = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = CW'(WIDTH - 1);
      par_d   = ^bus.load_data;
      sr_load = 1'b1;
      sr_din  = bus.load_data;
    end
    ser_last_d = (state_d == PAR) ||
                 ((state_d == SHIFT) && (cnt_d == '0) && !PARITY_EN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      ser_en_q   <= 1'b0;
      ser_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      ser_en_q   <= (state_d != IDLE);
      ser_last_q <= ser_last_d;
      done_q     <= final_bit;
    end
  end

  assign bus.ser_d    = sr_msb;
  assign bus.ser_en   = ser_en_q;
  assign bus.ser_last = ser_last_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_piso_tx_serializer.sv
// tb/tb_piso_tx_serializer.sv - bench for piso_tx_serializer, both parity settings
module tb_piso_tx_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  piso_tx_serializer_if #(.WIDTH(8)) a_if ();
  piso_tx_serializer_if #(.WIDTH(8)) b_if ();

  piso_tx_serializer #(.WIDTH(8), .PARITY_EN(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  piso_tx_serializer #(.WIDTH(8), .PARITY_EN(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  int errs   = 0;
  int checks = 0;
  bit sel;              // 0: no-parity instance, 1: parity instance

  // expected frame bits still to appear, each {d, last}
  logic [1:0] mq[$];
  bit         mdone;

  function automatic logic [4:0] obs_now();
    if (sel)
      return {b_if.ser_en, b_if.ser_d, b_if.ser_last, b_if.done, b_if.load_ready};
    return {a_if.ser_en, a_if.ser_d, a_if.ser_last, a_if.done, a_if.load_ready};
  endfunction

  // {ser_en, ser_d, ser_last, done, load_ready}
  function automatic logic [4:0] expv();
    if (mq.size() == 0)
      return {3'b000, mdone, 1'b1};
    return {1'b1, mq[0][1], mq[0][0], mdone, (mq.size() == 1)};
  endfunction

  task automatic model_edge(input bit acc, input logic [7:0] w);
    bit was_last;
    was_last = (mq.size() > 0) && mq[0][0];
    if (mq.size() > 0) void'(mq.pop_front());
    mdone = was_last;
    if (acc) begin
      for (int k = 7; k >= 0; k--) mq.push_back({w[k], (!sel && k == 0)});
      if (sel) mq.push_back({^w, 1'b1});
    end
  endtask

  // drive one cycle of load stimulus from a negedge to the next negedge
  task automatic tick(input bit v, input logic [7:0] w, output bit acc);
    if (sel) begin
      b_if.load_valid = v;
      b_if.load_data  = w;
    end else begin
      a_if.load_valid = v;
      a_if.load_data  = w;
    end
    acc = v && (mq.size() <= 1);
    @(posedge clk);
    model_edge(acc, w);
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_if.load_valid = 1'b0;
    a_if.load_data  = 8'h00;
    b_if.load_valid = 1'b0;
    b_if.load_data  = 8'h00;
    rst_n = 1'b0;
    mq.delete();
    mdone = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      checks++;
      if (obs_now() !== 5'b00001) begin
        errs++;
        $display("FAIL reset_held inst%0d got=%b exp=00001", s, obs_now());
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        sel = s[0];
        checks++;
        if (obs_now() !== 5'b00001) begin
          errs++;
          $display("FAIL reset_release inst%0d cyc%0d got=%b exp=00001", s, c, obs_now());
        end
      end
    end
  endtask

  task automatic test_single();
    bit acc;
    int en_cnt = 0;
    int done_at = -1;
    logic [7:0] bits = 8'h00;
    sel = 1'b0;
    tick(1'b1, 8'hA5, acc);
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (obs_now() !== expv()) begin
        errs++;
        $display("FAIL single cyc%0d got=%b exp=%b", c, obs_now(), expv());
      end
      if (obs_now()[4]) begin
        en_cnt++;
        bits = {bits[6:0], obs_now()[3]};
      end
      if (obs_now()[1] && done_at < 0) done_at = c;
      tick(1'b0, 8'h00, acc);
    end
    checks++;
    if (bits !== 8'hA5 || en_cnt != 8 || done_at != 9) begin
      errs++;
      $display("FAIL single_frame got bits=%h en=%0d done@%0d exp bits=a5 en=8 done@9",
               bits, en_cnt, done_at);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int en_cnt = 0;
    logic [7:0] words[$];
    words = '{8'hFF, 8'h00};
    sel = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs_now() !== expv()) begin
        errs++;
        $display("FAIL b2b cyc%0d got=%b exp=%b", c, obs_now(), expv());
      end
      if (obs_now()[4]) en_cnt++;
      tick(words.size() > 0, (words.size() > 0) ? words[0] : 8'h00, acc);
      if (acc) void'(words.pop_front());
    end
    checks++;
    if (en_cnt != 16) begin
      errs++;
      $display("FAIL b2b_en_count got=%0d exp=16", en_cnt);
    end
  endtask

  task automatic test_parity();
    bit acc;
    int en_cnt = 0;
    logic [1:0] pbits = 2'b00;
    logic [7:0] words[$];
    words = '{8'h07, 8'h03};
    sel = 1'b1;
    for (int c = 0; c < 22; c++) begin
      checks++;
      if (obs_now() !== expv()) begin
        errs++;
        $display("FAIL parity cyc%0d got=%b exp=%b", c, obs_now(), expv());
      end
      if (obs_now()[4]) en_cnt++;
      if (obs_now()[4] && obs_now()[2]) pbits = {pbits[0], obs_now()[3]};
      tick(words.size() > 0, (words.size() > 0) ? words[0] : 8'h00, acc);
      if (acc) void'(words.pop_front());
    end
    checks++;
    if (en_cnt != 18 || pbits !== 2'b10) begin
      errs++;
      $display("FAIL parity_bits got en=%0d par=%b exp en=18 par=10", en_cnt, pbits);
    end
  endtask

  task automatic test_midframe_reset();
    bit acc;
    sel = 1'b0;
    tick(1'b1, 8'hC3, acc);
    repeat (3) tick(1'b0, 8'h00, acc);
    checks++;
    if (obs_now() !== expv()) begin
      errs++;
      $display("FAIL midrst_bit3 got=%b exp=%b", obs_now(), expv());
    end
    rst_n = 1'b0;
    #1;
    mq.delete();
    mdone = 1'b0;
    checks++;
    if (obs_now() !== 5'b00001) begin
      errs++;
      $display("FAIL midrst_async got=%b exp=00001", obs_now());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (obs_now() !== expv()) begin
        errs++;
        $display("FAIL midrst_after cyc%0d got=%b exp=%b", c, obs_now(), expv());
      end
      tick(c == 0, 8'h81, acc);
    end
  endtask

  task automatic test_held_off();
    bit acc;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int c = 0; c < 44; c++) begin
        checks++;
        if (obs_now() !== expv()) begin
          errs++;
          $display("FAIL held_off inst%0d cyc%0d got=%b exp=%b", s, c, obs_now(), expv());
        end
        tick(c < 30, 8'($urandom), acc);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    bit pend;
    bit v;
    for (int s = 0; s < 2; s++) begin
      sel  = s[0];
      pend = 1'b0;
      for (int c = 0; c < 125; c++) begin
        checks++;
        if (obs_now() !== expv()) begin
          errs++;
          $display("FAIL random inst%0d cyc%0d got=%b exp=%b", s, c, obs_now(), expv());
        end
        v = pend || (c < 100 && ($urandom_range(0, 2) != 0));
        tick(v, 8'($urandom), acc);
        pend = v && !acc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_midframe_reset();
    test_held_off();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
